datamem_arbiter: RTL and testbench

- Shares the single-port, 256-entry byte DataMem between two requesters (port 0 = core load/store, port 1 = DMA/test loader).
- Round-robin arbitration: one access per cycle.
- Built-in clear sequencer zeroes every entry, one write per cycle, so the memory needs no bulk reset loop.
- Sits between the requesters and DataMem; it owns DataMem's WriteEn, DataAddress and DataIn, and observes DataOut.

---
 rtl/datamem_arbiter.sv | 129 ++++++++++++
 tb/tb_datamem_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/datamem_arbiter.sv
// rtl/datamem_arbiter.sv - two-port round-robin arbiter and clear sequencer for DataMem
//
// Shares a single-port 2**A x W DataMem between port 0 (core load/store)
// and port 1 (DMA / test loader), one access per cycle. A built-in clear
// sequencer writes zero to every entry, one entry per cycle.
//
// Ports:
//   Clk, ResetN                  clock, async active-low reset
//   Req{0,1}Valid/Write/Addr/Data request inputs
//   Req{0,1}Ready                combinational grant
//   Rsp{0,1}Valid/Data           registered read response, 1-cycle latency
//   ClearStart                   pulse: start a full-memory clear
//   ClearBusy, ClearDone         sweep in progress / pulse after last write
//   MemWriteEn/Address/DataIn    drive DataMem
//   MemDataOut                   DataMem combinational read data
module datamem_arbiter #(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic         Clk,
  input  logic         ResetN,
  input  logic         Req0Valid,
  input  logic         Req0Write,
  input  logic [A-1:0] Req0Addr,
  input  logic [W-1:0] Req0Data,
  output logic         Req0Ready,
  output logic         Rsp0Valid,
  output logic [W-1:0] Rsp0Data,
  input  logic         Req1Valid,
  input  logic         Req1Write,
  input  logic [A-1:0] Req1Addr,
  input  logic [W-1:0] Req1Data,
  output logic         Req1Ready,
  output logic         Rsp1Valid,
  output logic [W-1:0] Rsp1Data,
  input  logic         ClearStart,
  output logic         ClearBusy,
  output logic         ClearDone,
  output logic         MemWriteEn,
  output logic [A-1:0] MemAddress,
  output logic [W-1:0] MemDataIn,
  input  logic [W-1:0] MemDataOut
);

  typedef enum logic {ARB, CLEAR} state_t;

  state_t       state, state_next;
  logic         last_grant;   // port granted most recently; the other port wins a tie
  logic [A-1:0] clear_addr;
  logic         arb_en;
  logic         grant0, grant1;
  logic         clear_last;

  assign clear_last = (state == CLEAR) && (clear_addr == {A{1'b1}});

  // Grants are qualified by ResetN so nothing is granted while reset is held.
  assign arb_en = (state == ARB) && ResetN;
  assign grant0 = arb_en && Req0Valid && (!Req1Valid || last_grant);
  assign grant1 = arb_en && Req1Valid && !grant0;

  // State register
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) state <= ARB;
    else         state <= state_next;
  end

  // Next-state logic; ClearStart during CLEAR is ignored
  always_comb begin
    state_next = state;
    case (state)
      ARB:     if (ClearStart) state_next = CLEAR;
      CLEAR:   if (clear_last) state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  // Output logic
  always_comb begin
    Req0Ready  = grant0;
    Req1Ready  = grant1;
    ClearBusy  = (state == CLEAR);
    MemWriteEn = 1'b0;
    MemAddress = '0;
    MemDataIn  = '0;
    if (state == CLEAR) begin
      MemWriteEn = 1'b1;
      MemAddress = clear_addr;
    end else if (grant0) begin
      MemWriteEn = Req0Write;
      MemAddress = Req0Addr;
      MemDataIn  = Req0Data;
    end else if (grant1) begin
      MemWriteEn = Req1Write;
      MemAddress = Req1Addr;
      MemDataIn  = Req1Data;
    end
  end

  // Arbitration history, clear sweep address and done pulse
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      last_grant <= 1'b1;
      clear_addr <= '0;
      ClearDone  <= 1'b0;
    end else begin
      if (grant0)      last_grant <= 1'b0;
      else if (grant1) last_grant <= 1'b1;
      if (state == CLEAR)  clear_addr <= clear_addr + 1'b1;  // natural wrap to 0 after the last entry
      else if (ClearStart) clear_addr <= '0;
      ClearDone <= clear_last;
    end
  end

  // Read responses: data captured at the grant edge, held until the next read
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      Rsp0Valid <= 1'b0;
      Rsp0Data  <= '0;
      Rsp1Valid <= 1'b0;
      Rsp1Data  <= '0;
    end else begin
      Rsp0Valid <= grant0 && !Req0Write;
      Rsp1Valid <= grant1 && !Req1Write;
      if (grant0 && !Req0Write) Rsp0Data <= MemDataOut;
      if (grant1 && !Req1Write) Rsp1Data <= MemDataOut;
    end
  end

endmodule

// File: tb/tb_datamem_arbiter.sv
// tb/tb_datamem_arbiter.sv - self-checking bench for datamem_arbiter
module tb_datamem_arbiter;

  logic       Clk = 1'b0;
  logic       ResetN;
  logic       Req0Valid, Req0Write, Req0Ready, Rsp0Valid;
  logic [7:0] Req0Addr, Req0Data, Rsp0Data;
  logic       Req1Valid, Req1Write, Req1Ready, Rsp1Valid;
  logic [7:0] Req1Addr, Req1Data, Rsp1Data;
  logic       ClearStart, ClearBusy, ClearDone;
  logic       MemWriteEn;
  logic [7:0] MemAddress, MemDataIn, MemDataOut;

  always #5 Clk = ~Clk;

  datamem_arbiter #(.W(8), .A(8)) dut (
    .Clk(Clk), .ResetN(ResetN),
    .Req0Valid(Req0Valid), .Req0Write(Req0Write), .Req0Addr(Req0Addr), .Req0Data(Req0Data),
    .Req0Ready(Req0Ready), .Rsp0Valid(Rsp0Valid), .Rsp0Data(Rsp0Data),
    .Req1Valid(Req1Valid), .Req1Write(Req1Write), .Req1Addr(Req1Addr), .Req1Data(Req1Data),
    .Req1Ready(Req1Ready), .Rsp1Valid(Rsp1Valid), .Rsp1Data(Rsp1Data),
    .ClearStart(ClearStart), .ClearBusy(ClearBusy), .ClearDone(ClearDone),
    .MemWriteEn(MemWriteEn), .MemAddress(MemAddress), .MemDataIn(MemDataIn),
    .MemDataOut(MemDataOut)
  );

  // DataMem stand-in: combinational read, synchronous write
  logic [7:0] env_mem [256];
  assign MemDataOut = env_mem[MemAddress];
  always @(posedge Clk) if (MemWriteEn) env_mem[MemAddress] <= MemDataIn;

  // Reference model: memory contents, tie-break history, clear progress, expected responses
  logic [7:0] ref_mem [256];
  bit         m_last;
  bit         m_clearing;
  int         m_idx;
  bit         m_done;
  bit         m_rv [2];
  logic [7:0] m_rd [2];
  int         last_pick;
  int         obs_busy_cnt;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last     = 1'b1;
    m_clearing = 1'b0;
    m_idx      = 0;
    m_done     = 1'b0;
    m_rv       = '{1'b0, 1'b0};
    m_rd       = '{8'h00, 8'h00};
  endtask

  task automatic drive(input int p, input bit v, input bit w, input logic [7:0] a, input logic [7:0] d);
    if (p == 0) begin
      Req0Valid = v; Req0Write = w; Req0Addr = a; Req0Data = d;
    end else begin
      Req1Valid = v; Req1Write = w; Req1Addr = a; Req1Data = d;
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 8'h00, 8'h00);
    drive(1, 0, 0, 8'h00, 8'h00);
  endtask

  // One clock cycle: check combinational outputs at the falling edge,
  // then advance the model and check registered outputs after the rising edge.
  task automatic step();
    int         pick;
    bit         wr;
    logic [7:0] a, d;
    @(negedge Clk);
    if (ClearBusy === 1'b1) obs_busy_cnt++;
    chk("clear_done", ClearDone, m_done);
    pick = -1; wr = 0; a = 0; d = 0;
    if (m_clearing) begin
      chk("busy_clr", ClearBusy, 1);
      chk("ready0_clr", Req0Ready, 0);
      chk("ready1_clr", Req1Ready, 0);
      chk("we_clr", MemWriteEn, 1);
      chk("addr_clr", MemAddress, m_idx);
      chk("din_clr", MemDataIn, 0);
    end else begin
      if (Req0Valid && Req1Valid) pick = m_last ? 0 : 1;
      else if (Req0Valid)         pick = 0;
      else if (Req1Valid)         pick = 1;
      if (pick == 0) begin wr = Req0Write; a = Req0Addr; d = Req0Data; end
      if (pick == 1) begin wr = Req1Write; a = Req1Addr; d = Req1Data; end
      chk("busy_arb", ClearBusy, 0);
      chk("ready0", Req0Ready, pick == 0);
      chk("ready1", Req1Ready, pick == 1);
      chk("mem_we", MemWriteEn, (pick >= 0) && wr);
      chk("mem_addr", MemAddress, a);
      chk("mem_din", MemDataIn, (pick >= 0) ? d : 8'h00);
    end
    last_pick = pick;
    @(posedge Clk); #1;
    m_rv = '{1'b0, 1'b0};
    if (pick >= 0) begin
      if (wr) ref_mem[a] = d;
      else begin
        m_rv[pick] = 1'b1;
        m_rd[pick] = ref_mem[a];
      end
      m_last = (pick == 1);
    end
    m_done = 1'b0;
    if (m_clearing) begin
      ref_mem[m_idx] = 8'h00;
      m_idx++;
      if (m_idx == 256) begin
        m_clearing = 1'b0;
        m_idx      = 0;
        m_done     = 1'b1;
      end
    end else if (ClearStart) begin
      m_clearing = 1'b1;
      m_idx      = 0;
    end
    chk("rsp0_valid", Rsp0Valid, m_rv[0]);
    chk("rsp1_valid", Rsp1Valid, m_rv[1]);
    chk("rsp0_data", Rsp0Data, m_rd[0]);
    chk("rsp1_data", Rsp1Data, m_rd[1]);
  endtask

  initial begin
    logic [7:0] old_ff;
    ResetN     = 1'b0;
    ClearStart = 1'b0;
    idle();
    Req0Valid  = 1'b1;
    obs_busy_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 8'($urandom);
      ref_mem[i] = env_mem[i];
    end
    model_reset();

    // Reset held with a pending request
    repeat (2) begin
      @(negedge Clk);
      chk("rst_ready0", Req0Ready, 0);
      chk("rst_we", MemWriteEn, 0);
      chk("rst_rsp0_valid", Rsp0Valid, 0);
      chk("rst_rsp1_valid", Rsp1Valid, 0);
      chk("rst_rsp0_data", Rsp0Data, 0);
      chk("rst_rsp1_data", Rsp1Data, 0);
      chk("rst_busy", ClearBusy, 0);
      chk("rst_done", ClearDone, 0);
    end
    @(posedge Clk); #1;
    ResetN = 1'b1;
    drive(0, 1, 0, 8'h33, 8'h00);
    step();
    chk("first_grant_port0", last_pick, 0);

    // Single port write then read
    drive(0, 1, 1, 8'h10, 8'hA5); step();
    drive(0, 1, 0, 8'h10, 8'h00); step();
    chk("single_rsp_valid", Rsp0Valid, 1);
    chk("single_rsp_data", Rsp0Data, 8'hA5);

    // Make port 1 the last winner so contention starts with port 0
    idle();
    drive(1, 1, 0, 8'h20, 8'h00); step();

    // Contention: both valid for 6 cycles
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0, 8'($urandom), 8'h00);
      drive(1, 1, 0, 8'($urandom), 8'h00);
      step();
      chk("contend_order", last_pick, i % 2);
    end

    // Ordering: same-cycle write (port 1) and read (port 0) of 0xFF
    old_ff = ref_mem[8'hFF];
    drive(0, 1, 0, 8'hFF, 8'h00);
    drive(1, 1, 1, 8'hFF, 8'h3C);
    step();
    chk("order_old_data", Rsp0Data, old_ff);
    drive(0, 0, 0, 8'h00, 8'h00); step();
    drive(0, 1, 0, 8'hFF, 8'h00);
    drive(1, 0, 0, 8'h00, 8'h00);
    step();
    chk("order_new_data", Rsp0Data, 8'h3C);

    // Clear: preload, read granted in the ClearStart cycle, stalled request, ignored restart
    idle();
    drive(1, 1, 1, 8'h00, 8'h11); step();
    drive(1, 1, 1, 8'hFF, 8'h22); step();
    idle();
    drive(0, 1, 0, 8'h00, 8'h00);
    ClearStart = 1'b1;
    obs_busy_cnt = 0;
    step();
    ClearStart = 1'b0;
    chk("clear_pre_rsp_valid", Rsp0Valid, 1);
    chk("clear_pre_rsp_data", Rsp0Data, 8'h11);
    for (int k = 0; k < 400 && m_clearing; k++) begin
      ClearStart = (k == 100);
      step();
    end
    ClearStart = 1'b0;
    chk("clear_len", obs_busy_cnt, 256);
    step();  // ClearDone cycle; stalled read of 0x00 is granted here
    chk("clear_rd00", Rsp0Data, 8'h00);
    drive(0, 1, 0, 8'hFF, 8'h00); step();
    chk("clear_rdff", Rsp0Data, 8'h00);

    // Randomized traffic with occasional clears
    for (int i = 0; i < 600; i++) begin
      drive(0, ($urandom_range(0, 3) != 0), $urandom_range(0, 1), 8'($urandom), 8'($urandom));
      drive(1, ($urandom_range(0, 3) != 0), $urandom_range(0, 1), 8'($urandom), 8'($urandom));
      ClearStart = ($urandom_range(0, 299) == 0);
      step();
    end
    ClearStart = 1'b0;
    idle();
    for (int k = 0; k < 300 && m_clearing; k++) step();
    step();

    // Abort: reset at ClearAddr 0x40
    drive(1, 1, 1, 8'h80, 8'h5A); step();
    idle();
    ClearStart = 1'b1; step();
    ClearStart = 1'b0;
    drive(0, 1, 0, 8'h80, 8'h00);
    for (int k = 0; k < 300 && m_clearing && m_idx != 8'h40; k++) step();
    chk("abort_at_40", m_idx, 8'h40);
    ResetN = 1'b0;
    #1;
    chk("abort_busy", ClearBusy, 0);
    chk("abort_we", MemWriteEn, 0);
    chk("abort_ready0", Req0Ready, 0);
    model_reset();
    repeat (2) begin
      @(negedge Clk);
      chk("abort_no_done", ClearDone, 0);
      chk("abort_busy_held", ClearBusy, 0);
    end
    @(posedge Clk); #1;
    ResetN = 1'b1;
    step();
    chk("abort_keep_80", Rsp0Data, 8'h5A);
    drive(0, 1, 0, 8'h3F, 8'h00); step();
    chk("abort_cleared_3f", Rsp0Data, 8'h00);
    drive(0, 1, 0, 8'h40, 8'h00); step();
    idle(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
